register_file: RTL and testbench

Architectural register file for the single-cycle CPU datapath: eight 8-bit general registers with one synchronous write port and two combinational read ports. Register addresses are decoded directly from the 16-bit instruction word. Write data is supplied by the datapath (ALU/memory result) and gated by the control unit's `reg_en`.

---
 rtl/register_pkg.sv | 26 ++
 rtl/reg_cell.sv | 37 +++
 rtl/register_file.sv | 87 ++++++++
 tb/tb_register_file.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_pkg
//  Description : Shared constants and types for the CPU register file:
//                data/address widths, instruction-word field positions of
//                the rd/rs1 and rs2 register address fields, and the
//                register address/word typedefs.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    // Register address fields inside the 16-bit instruction word
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS2_MSB  = 8;
    localparam int RS2_LSB  = 6;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_word_t;

endpackage : register_pkg
`default_nettype wire

// File: rtl/reg_cell.sv
`default_nettype none
// ============================================================================
//  Module      : reg_cell
//  Description : One register of the register file: a WIDTH-bit flop with
//                asynchronous active-high clear and a synchronous write
//                enable.
//  Ports       : clk  - clock, captures on rising edge
//                rst  - asynchronous active-high clear
//                en   - write enable
//                d    - write data
//                q    - stored value
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : reg_cell
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Architectural register file of the single-cycle CPU.
//                NUM_REGS registers of DATA_W bits, one synchronous write
//                port and two combinational read ports. Addresses come
//                straight from the instruction word: inst[11:9] is both
//                the write address and read port 1, inst[8:6] is read
//                port 2. Reads have no write bypass.
//  Ports       : clk       - clock, writes on rising edge
//                rst       - asynchronous active-high clear of all registers
//                inst      - 16-bit instruction word (address fields)
//                reg_en    - write enable for register inst[11:9]
//                data      - write data
//                reg_data1 - contents of register inst[11:9]
//                reg_data2 - contents of register inst[8:6]
//  Config      : REG_ZERO_EN - when defined, register 0 is hardwired to
//                zero; writes to it are dropped and reads return 0.
//  Revision    : 1.0 - initial release
// ============================================================================
import register_pkg::*;

module register_file #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       inst,
    input  logic              reg_en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] reg_data1,
    output logic [DATA_W-1:0] reg_data2
);

    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic [DATA_W-1:0] w_regs [NUM_REGS];

    // Opcode and low immediate/function bits play no part in register access
    logic              w_unused_inst_bits;

    assign w_addr1            = inst[RD_MSB:RD_LSB];
    assign w_addr2            = inst[RS2_MSB:RS2_LSB];
    assign w_unused_inst_bits = ^{inst[15:12], inst[5:0]};

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_regs
`ifdef REG_ZERO_EN
            if (i == 0) begin : g_zero
                assign w_regs[i] = '0;
            end else begin : g_cell
                reg_cell #(
                    .WIDTH (DATA_W)
                ) u_reg_cell (
                    .clk (clk),
                    .rst (rst),
                    .en  (reg_en && (w_addr1 == ADDR_W'(i))),
                    .d   (data),
                    .q   (w_regs[i])
                );
            end
`else
            begin : g_cell
                reg_cell #(
                    .WIDTH (DATA_W)
                ) u_reg_cell (
                    .clk (clk),
                    .rst (rst),
                    .en  (reg_en && (w_addr1 == ADDR_W'(i))),
                    .d   (data),
                    .q   (w_regs[i])
                );
            end
`endif
        end
    endgenerate

    // Read ports come straight from the flops, so a same-address write is
    // only seen after the capturing edge.
    assign reg_data1 = w_regs[w_addr1];
    assign reg_data2 = w_regs[w_addr2];

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file. Directed steps for
//                reset, write/read, enable gating, dual read and reset
//                priority, followed by random instructions checked against
//                an array model of the eight registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [15:0] inst;
    logic        reg_en;
    logic [7:0]  data;
    logic [7:0]  reg_data1;
    logic [7:0]  reg_data2;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [8];

    register_file #(
        .DATA_W   (8),
        .NUM_REGS (8),
        .ADDR_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .reg_en    (reg_en),
        .data      (data),
        .reg_data1 (reg_data1),
        .reg_data2 (reg_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int a);
`ifdef REG_ZERO_EN
        if (a == 0) return 8'h00;
`endif
        return model[a];
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        model[a] = d;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) model[k] = 8'h00;
    endfunction

    // Address fields placed in inst; the ignored bits get random junk
    task automatic set_inst(input int a1, input int a2);
        inst = {4'($urandom), 3'(a1), 3'(a2), 6'($urandom)};
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, reg_data1, model_read(int'(inst[11:9])));
        check({tag, "_rd2"}, reg_data2, model_read(int'(inst[8:6])));
    endtask

    // Drive at the falling edge, apply one rising edge, sample 1 time unit later
    task automatic step(input int a1, input int a2, input logic en, input logic [7:0] d);
        @(negedge clk);
        set_inst(a1, a2);
        reg_en = en;
        data   = d;
        @(posedge clk);
        if (en && !rst) model_write(a1, d);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        inst   = 16'h0000;
        reg_en = 1'b0;
        data   = 8'h00;
        model_clear();

        // Reset visible before any clock edge
        #1;
        check("reset_noedge_rd1", reg_data1, 8'h00);
        check("reset_noedge_rd2", reg_data2, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            set_inst(a, 7 - a);
            #1;
            check_ports("after_reset");
        end

        // Edges with reg_en low leave register 3 at zero
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            inst = 16'hF600; reg_en = 1'b0; data = 8'hAA;
            @(posedge clk); #1;
        end
        check("noen_reg3", reg_data1, 8'h00);

        // No bypass: enabled write not visible before the edge
        @(negedge clk);
        inst = 16'hF600; reg_en = 1'b1; data = 8'hAA;
        #1;
        check("prewrite_reg3", reg_data1, 8'h00);
        @(posedge clk);
        model_write(3, 8'hAA);
        #1;
        check("write_reg3", reg_data1, 8'hAA);

        // Enable gating
        for (int n = 0; n < 3; n++) step(3, 0, 1'b0, 8'h55);
        check("gate_reg3", reg_data1, 8'hAA);

        // Combinational read address switch
        @(negedge clk);
        reg_en = 1'b0;
        inst = 16'hF400; #1;
        check("switch_reg2", reg_data1, 8'h00);
        inst = 16'hF600; #1;
        check("switch_reg3", reg_data1, 8'hAA);

        // Dual read
        step(5, 0, 1'b1, 8'h3C);
        @(negedge clk);
        reg_en = 1'b0;
        inst = 16'h0740; #1;
        check("dual_rd1", reg_data1, 8'hAA);
        check("dual_rd2", reg_data2, 8'h3C);

        // Address 0 write (dropped when register 0 is hardwired)
        step(0, 0, 1'b1, 8'hFF);
        check_ports("zero_write");

        // Random instructions against the model
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            inst   = 16'($urandom);
            reg_en = 1'($urandom);
            data   = 8'($urandom);
            #1;
            check_ports("rand_pre");
            @(posedge clk);
            if (reg_en) model_write(int'(inst[11:9]), data);
            #1;
            check_ports("rand_post");
        end

        // Make sure something nonzero is visible, then reset mid-cycle
        step(4, 4, 1'b1, 8'h5A);
        check("pre_reset_reg4", reg_data1, 8'h5A);
        @(negedge clk);
        reg_en = 1'b0;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("midreset_rd1", reg_data1, 8'h00);
        check("midreset_rd2", reg_data2, 8'h00);

        // Reset wins over a simultaneous write
        step(3, 3, 1'b1, 8'h77);
        check("reset_priority", reg_data1, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        reg_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            set_inst(a, a);
            #1;
            check_ports("post_reset");
        end

        // Writes work again after release
        step(6, 3, 1'b1, 8'hC3);
        check_ports("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_register_file
`default_nettype wire
